fetch_ctrl: RTL and testbench

Instruction-fetch controller that owns the program counter and sequences fetches over a request/grant/response instruction-memory port. Selects the next PC from trap redirects, jump redirects and sequential flow, allowing one outstanding fetch at a time. Holds each fetched instruction in a one-entry buffer until decode accepts it. Discards responses made stale by a redirect. Sits between execute/trap logic (redirect sources), instruction memory and the decode stage.

---
 rtl/fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_fetch_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, issues one fetch at a time over a
// req/gnt/rvalid port, buffers the returned word for decode, and drops stale responses.
module fetch_ctrl #(
  parameter logic [31:0] PC_RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_flag,
  input  logic [31:0] trap_addr,
  input  logic        jump_flag,
  input  logic [31:0] jump_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] w_fetch_pc_next;
  logic [31:0] r_if_pc;
  logic [31:0] w_if_pc_next;
  logic [31:0] r_if_instr;
  logic [31:0] w_if_instr_next;
  logic        r_kill;
  logic        w_kill_next;

  logic        w_redirect;
  logic [31:0] w_target;

  assign w_redirect = trap_flag | jump_flag;
  assign w_target   = (trap_flag ? trap_addr : jump_addr) & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= PC_RESET_ADDR;
      r_fetch_pc <= 32'h0000_0000;
      r_if_pc    <= 32'h0000_0000;
      r_if_instr <= NOP_INSTR;
      r_kill     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_if_pc    <= w_if_pc_next;
      r_if_instr <= w_if_instr_next;
      r_kill     <= w_kill_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_fetch_pc_next = r_fetch_pc;
    w_if_pc_next    = r_if_pc;
    w_if_instr_next = r_if_instr;
    w_kill_next     = r_kill;

    case (r_state)
      S_IDLE: begin
        w_state_next = S_REQ;
        if (w_redirect) w_pc_next = w_target;
      end

      S_REQ: begin
        if (imem_gnt) begin
          // The old address is already accepted, so a same-cycle redirect
          // must mark its response stale rather than cancel it.
          w_state_next    = S_WAIT;
          w_fetch_pc_next = r_pc;
          w_pc_next       = w_redirect ? w_target : r_pc + 32'd4;
          w_kill_next     = w_redirect;
        end else if (w_redirect) begin
          w_pc_next = w_target;
        end
      end

      S_WAIT: begin
        if (imem_rvalid) begin
          if (r_kill || w_redirect) begin
            w_state_next = S_REQ;
            w_kill_next  = 1'b0;
            if (w_redirect) w_pc_next = w_target;
          end else begin
            w_state_next    = S_HOLD;
            w_if_instr_next = imem_rdata;
            w_if_pc_next    = r_fetch_pc;
          end
        end else if (w_redirect) begin
          w_kill_next = 1'b1;
          w_pc_next   = w_target;
        end
      end

      S_HOLD: begin
        // A redirect drops the buffered word even if decode is ready.
        if (w_redirect) begin
          w_pc_next    = w_target;
          w_state_next = S_REQ;
        end else if (id_ready) begin
          w_state_next = S_REQ;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign imem_req  = (r_state == S_REQ);
  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign if_valid  = (r_state == S_HOLD);
  assign if_pc     = r_if_pc;
  assign if_instr  = r_if_instr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the bench plays instruction memory, queues the
// words it expects decode to see, and checks them as the buffer fills.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trap_flag = 1'b0;
  logic [31:0] trap_addr = 32'h0;
  logic        jump_flag = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready = 1'b0;
  logic [31:0] pc;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic        prev_valid = 1'b0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trap_flag  (trap_flag),
    .trap_addr  (trap_addr),
    .jump_flag  (jump_flag),
    .jump_addr  (jump_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr),
    .id_ready   (id_ready),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each new buffer fill must match the oldest queued expectation.
  always @(negedge clk) begin
    if (if_valid && !prev_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got if_pc=%h if_instr=%h, required no buffered instruction", if_pc, if_instr);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({if_pc, if_instr} !== e) begin
          n_fail++;
          $display("FAIL sb_word: got if_pc=%h if_instr=%h, required if_pc=%h if_instr=%h", if_pc, if_instr, e[63:32], e[31:0]);
        end else begin
          $display("txn: decode buffer if_pc=%h if_instr=%h", if_pc, if_instr);
        end
      end
    end
    prev_valid = if_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got req=%b valid=%b, required 0 0", imem_req, if_valid);
    end
    n_checks++;
    if (pc !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_pc: got pc=%h addr=%h, required 0", pc, imem_addr);
    end
    n_checks++;
    if (if_pc !== 32'h0 || if_instr !== NOP) begin
      n_fail++;
      $display("FAIL reset_buf: got if_pc=%h if_instr=%h, required 0 %h", if_pc, if_instr, NOP);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h, required 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      logic [31:0] a;
      a = 32'(i * 4);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        n_fail++;
        $display("FAIL seq_req: got req=%b addr=%h, required 1 %h", imem_req, imem_addr, a);
      end
      imem_gnt = 1'b1;
      exp_q.push_back({a, instr_of(a)});
      tick();
      imem_gnt = 1'b0;
      n_checks++;
      if (imem_req !== 1'b0 || pc !== a + 32'd4) begin
        n_fail++;
        $display("FAIL seq_wait: got req=%b pc=%h, required 0 %h", imem_req, pc, a + 32'd4);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(a);
      tick();
      imem_rvalid = 1'b0;
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== a || if_instr !== instr_of(a)) begin
        n_fail++;
        $display("FAIL seq_hold: got valid=%b if_pc=%h instr=%h, required 1 %h %h", if_valid, if_pc, if_instr, a, instr_of(a));
      end
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    imem_gnt = 1'b1;
    exp_q.push_back({32'hC, instr_of(32'hC)});
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(32'hC);
    tick();
    imem_rvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== instr_of(32'hC) || imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: got valid=%b if_pc=%h instr=%h req=%b, required 1 0000000c %h 0", if_valid, if_pc, if_instr, imem_req, instr_of(32'hC));
      end
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_release: got req=%b addr=%h, required 1 00000010", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    tick();
    imem_gnt  = 1'b0;
    jump_flag = 1'b1;
    jump_addr = 32'h203;
    tick();
    jump_flag = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0 || pc !== 32'h200) begin
      n_fail++;
      $display("FAIL wait_redirect_pc: got req=%b pc=%h, required 0 00000200", imem_req, pc);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++;
      $display("FAIL wait_kill_drop: got valid=%b req=%b addr=%h, required 0 1 00000200", if_valid, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    exp_q.push_back({32'h200, instr_of(32'h200)});
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(32'h200);
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL wait_refetch: got valid=%b if_pc=%h, required 1 00000200", if_valid, if_pc);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  task automatic test_trap_jump_req();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin
      n_fail++;
      $display("FAIL req_entry: got req=%b addr=%h, required 1 00000204", imem_req, imem_addr);
    end
    trap_flag = 1'b1;
    trap_addr = 32'h100;
    jump_flag = 1'b1;
    jump_addr = 32'h80;
    imem_gnt  = 1'b1;
    tick();
    trap_flag = 1'b0;
    jump_flag = 1'b0;
    imem_gnt  = 1'b0;
    n_checks++;
    if (imem_req !== 1'b0 || pc !== 32'h100) begin
      n_fail++;
      $display("FAIL req_trap_gnt: got req=%b pc=%h, required 0 00000100", imem_req, pc);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_2222;
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL req_kill_drop: got valid=%b req=%b addr=%h, required 0 1 00000100", if_valid, imem_req, imem_addr);
    end
    // Redirect arriving together with the response.
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h3333_4444;
    jump_flag   = 1'b1;
    jump_addr   = 32'h40;
    tick();
    imem_rvalid = 1'b0;
    jump_flag   = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL wait_rvalid_redirect: got valid=%b req=%b addr=%h, required 0 1 00000040", if_valid, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    exp_q.push_back({32'h40, instr_of(32'h40)});
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(32'h40);
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40) begin
      n_fail++;
      $display("FAIL post_coincide_fetch: got valid=%b if_pc=%h, required 1 00000040", if_valid, if_pc);
    end
  endtask

  task automatic test_redirect_hold();
    jump_flag = 1'b1;
    jump_addr = 32'hFFFF_FFFE;
    id_ready  = 1'b1;
    tick();
    jump_flag = 1'b0;
    id_ready  = 1'b0;
    n_checks++;
    if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL hold_redirect: got valid=%b req=%b addr=%h, required 0 1 fffffffc", if_valid, imem_req, imem_addr);
    end
    imem_gnt = 1'b1;
    exp_q.push_back({32'hFFFF_FFFC, instr_of(32'hFFFF_FFFC)});
    tick();
    imem_gnt = 1'b0;
    n_checks++;
    if (pc !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got pc=%h, required 00000000", pc);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_hold: got valid=%b if_pc=%h, required 1 fffffffc", if_valid, if_pc);
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next_req: got req=%b addr=%h, required 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_async_reset();
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset_ctrl: got req=%b valid=%b pc=%h addr=%h, required 0 0 0 0", imem_req, if_valid, pc, imem_addr);
    end
    n_checks++;
    if (if_pc !== 32'h0 || if_instr !== NOP) begin
      n_fail++;
      $display("FAIL async_reset_buf: got if_pc=%h if_instr=%h, required 0 %h", if_pc, if_instr, NOP);
    end
    tick();
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h5555_AAAA;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_req: got req=%b addr=%h valid=%b, required 1 0 0", imem_req, imem_addr, if_valid);
    end
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || if_valid !== 1'b0 || if_instr !== NOP) begin
      n_fail++;
      $display("FAIL stray_rvalid: got req=%b valid=%b instr=%h, required 1 0 %h", imem_req, if_valid, if_instr, NOP);
    end
    imem_gnt = 1'b1;
    exp_q.push_back({32'h0, instr_of(32'h0)});
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = instr_of(32'h0);
    tick();
    imem_rvalid = 1'b0;
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== instr_of(32'h0)) begin
      n_fail++;
      $display("FAIL post_reset_fetch: got valid=%b if_pc=%h instr=%h, required 1 0 %h", if_valid, if_pc, if_instr, instr_of(32'h0));
    end
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_trap_jump_req();
    test_redirect_hold();
    test_async_reset();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d undelivered instructions, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
